// File: rtl/pwm_dac_pkg.sv
`default_nettype none
// ============================================================================
// pwm_dac_pkg : shared FSM encoding and constants for the PWM sample fetcher
// Rev 1.0
// ============================================================================
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam int unsigned c_word_stride = 4;

  localparam int c_def_div0 = 1000;
  localparam int c_def_div1 = 500;
  localparam int c_def_div2 = 250;
  localparam int c_def_div3 = 125;

  localparam int c_tcnt_w = 16;

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// pwm_tick_gen : sample-rate tick from a selectable divisor
// Rev 1.0
// ============================================================================
module pwm_tick_gen
  import pwm_dac_pkg::*;
#(
  parameter int DIV0 = c_def_div0,
  parameter int DIV1 = c_def_div1,
  parameter int DIV2 = c_def_div2,
  parameter int DIV3 = c_def_div3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic [1:0] i_freq_sel,
  output logic       o_tick,
  output logic       o_en_rise
);

  logic [c_tcnt_w-1:0] r_tcnt;
  logic [c_tcnt_w-1:0] w_div_m1;
  logic [1:0]          r_fsel_q;
  logic                r_en_q;
  logic                w_restart;

  always_comb begin
    w_div_m1 = c_tcnt_w'(DIV0 - 1);
    case (i_freq_sel)
      2'd1:    w_div_m1 = c_tcnt_w'(DIV1 - 1);
      2'd2:    w_div_m1 = c_tcnt_w'(DIV2 - 1);
      2'd3:    w_div_m1 = c_tcnt_w'(DIV3 - 1);
      default: w_div_m1 = c_tcnt_w'(DIV0 - 1);
    endcase
  end

  // Restarting on the enable edge too makes the first tick land a full period after enable.
  assign w_restart = !i_enable || !r_en_q || (i_freq_sel != r_fsel_q);
  assign o_tick    = !w_restart && (r_tcnt == w_div_m1);
  assign o_en_rise = i_enable && !r_en_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tcnt   <= '0;
      r_fsel_q <= 2'd0;
      r_en_q   <= 1'b0;
    end else begin
      r_en_q   <= i_enable;
      r_fsel_q <= i_freq_sel;
      if (w_restart || o_tick) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_sample_fetch.sv
`default_nettype none
// ============================================================================
// pwm_sample_fetch : Avalon-MM reader streaming a circular sample table to PWM
// Rev 1.0
// ============================================================================
module pwm_sample_fetch
  import pwm_dac_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIV0   = c_def_div0,
  parameter int DIV1   = c_def_div1,
  parameter int DIV2   = c_def_div2,
  parameter int DIV3   = c_def_div3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic [1:0]        freq_sel,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       sample_out,
  output logic              sample_strobe,
  output logic              underrun
);

  fetch_state_e      r_state;
  logic [31:0]       r_buf;
  logic              r_full;
  logic [15:0]       r_idx;
  logic [15:0]       r_nwords;
  logic              r_abort;
  logic [ADDR_W-1:0] r_avm_address;
  logic              r_avm_read;
  logic [31:0]       r_sample;
  logic              r_strobe;
  logic              r_underrun;

  logic              w_tick;
  logic              w_en_rise;
  logic [ADDR_W-1:0] w_req_addr;
  logic [15:0]       w_idx_next;

  pwm_tick_gen #(
    .DIV0 (DIV0),
    .DIV1 (DIV1),
    .DIV2 (DIV2),
    .DIV3 (DIV3)
  ) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enable   (enable),
    .i_freq_sel (freq_sel),
    .o_tick     (w_tick),
    .o_en_rise  (w_en_rise)
  );

  assign w_req_addr = base_addr + ADDR_W'(r_idx) * ADDR_W'(c_word_stride);
  assign w_idx_next = (r_idx >= r_nwords - 16'd1) ? 16'd0 : r_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_avm_read    <= 1'b0;
      r_avm_address <= '0;
      r_buf         <= '0;
      r_full        <= 1'b0;
      r_idx         <= '0;
      r_nwords      <= '0;
      r_abort       <= 1'b0;
      r_sample      <= '0;
      r_strobe      <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;

      if (w_tick) begin
        if (r_full) begin
          r_sample <= r_buf;
          r_strobe <= 1'b1;
          r_full   <= 1'b0;
        end else begin
          r_underrun <= 1'b1;
        end
      end else if (w_en_rise) begin
        r_underrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (!enable) begin
            r_full <= 1'b0;
            r_idx  <= '0;
          end else if (num_words != 16'd0 && !r_full) begin
            r_state       <= ST_REQ;
            r_avm_read    <= 1'b1;
            r_avm_address <= w_req_addr;
            r_nwords      <= num_words;
          end
        end
        ST_REQ: begin
          if (!enable) r_abort <= 1'b1;
          if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable) r_abort <= 1'b1;
          // A read that outlived its enable is drained and dropped; the table restarts at word 0.
          if (avm_readdatavalid) begin
            r_state <= ST_IDLE;
            if (r_abort || !enable) begin
              r_full <= 1'b0;
              r_idx  <= '0;
            end else begin
              r_buf  <= avm_readdata;
              r_full <= 1'b1;
              r_idx  <= w_idx_next;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_avm_read <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address   = r_avm_address;
  assign avm_read      = r_avm_read;
  assign sample_out    = r_sample;
  assign sample_strobe = r_strobe;
  assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: doc/pwm_sample_fetch.md
# pwm_sample_fetch

Avalon-MM read initiator that streams a waveform table from memory into the PWM DAC datapath. It fetches 32-bit sample words from a circular table in system memory using a one-entry prefetch buffer, and presents one sample per sample tick. The tick rate is chosen by the 2-bit `freq_sel` value driven by the frequency PIO. It sits between the system interconnect (as a master) and the PWM generator (as its sample source).

## Interface
- `ADDR_W`, 32: Avalon address width (byte addresses).
- `DIV0`, 1000: tick divisor when `freq_sel`=0 (50 kS/s at 50 MHz).
- `DIV1`, 500: tick divisor when `freq_sel`=1.
- `DIV2`, 250: tick divisor when `freq_sel`=2.
- `DIV3`, 125: tick divisor when `freq_sel`=3. All divisors are ≥2.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `enable` in 1: run control; level-sensitive.
- `base_addr` in ADDR_W: byte address of table word 0, 4-byte aligned.
- `num_words` in 16: table length in words.
- `freq_sel` in 2: sample-rate select.
- `avm_address` out ADDR_W: read address.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 32: read data.
- `avm_readdatavalid` in 1: read data qualifier.
- `sample_out` out 32: current sample to PWM, held between ticks.
- `sample_strobe` out 1: one-cycle pulse when `sample_out` updates.
- `underrun` out 1: sticky; a tick found the buffer empty.

## Operation
- Tick counter `tcnt` counts 0..DIV[freq_sel]-1. `tick` is asserted when `tcnt`=DIV-1, then `tcnt` wraps to 0. `tcnt` is cleared when `enable`=0 and on any change of `freq_sel`, detected via a registered copy.
- Prefetch buffer: one 32-bit word plus a `full` flag. Word index `idx` is 16 bits.
- FSM states:
  - IDLE: if `enable` && `num_words`≠0 && !`full`, go to REQ.
  - REQ: `avm_read`=1 and `avm_address`=`base_addr`+4·`idx`. Both are held stable while `avm_waitrequest`=1. When `avm_waitrequest`=0, go to WAIT.
  - WAIT: on `avm_readdatavalid`, load the buffer, set `full`, advance `idx` (wraps to 0 after `num_words`-1), go to IDLE.
- At most one read is outstanding at any time.
- On `tick` with `full`=1: `sample_out`←buffer, `sample_strobe`=1, clear `full`.
- On `tick` with `full`=0: `sample_out` is unchanged, no strobe, `underrun`←1.
- Tick and data arriving in the same cycle with `full`=0: counts as underrun. The arriving word loads the buffer; there is no bypass.
- `enable` falling:
  - No new request is issued.
  - A request in REQ is completed through its acceptance, and WAIT runs until readdatavalid. The returned data is discarded.
  - Then `full`←0 and `idx`←0.
  - `sample_out` holds its value. `underrun` holds.
- `enable` rising (registered edge): `underrun`←0.
- `num_words` and `base_addr` are sampled on each request and may only be changed while `enable`=0.

## Timing
- Reset values: `avm_read`=0, `avm_address`=0, `sample_out`=0, `sample_strobe`=0, `underrun`=0, state IDLE, `full`=0, `idx`=0, `tcnt`=0.
- `enable` high in cycle N (buffer empty): `avm_read` is asserted in cycle N+1.
- readdatavalid in cycle M: `full`=1 in M+1, and the next request cannot start before M+2.
- Strobe timing: `sample_strobe` and the new `sample_out` appear in the cycle after the tick cycle.
- First tick occurs DIV cycles after `enable` rises.
- Refill budget: sustained rate requires the read latency to be under DIV-2 cycles.

## Structure
- Shared package `pwm_dac_pkg` holds:
  - the FSM state enum (IDLE/REQ/WAIT);
  - the word-stride constant (4);
  - the default divisor constants.
- One sub-module, `pwm_tick_gen`, contains the divisor mux, `tcnt`, and the `freq_sel` change detect.

## Test plan
- Zero-wait memory, `num_words`=4, table {0x10,0x20,0x30,0x40}, `freq_sel`=3 → strobes every 125 cycles with 0x10,0x20,0x30,0x40,0x10; addresses base+0,4,8,12,0.
- `avm_waitrequest` held for 5 cycles → `avm_address`/`avm_read` stable for all 5 cycles; exactly one read accepted.
- Read latency 200 cycles, `freq_sel`=3 → `underrun`=1 after the first tick, and no strobe on that tick. Toggling `enable` 1→0→1 → `underrun`=0.
- `enable` dropped while in WAIT → FSM waits for readdatavalid, the data is discarded, and no further `avm_read`. Re-enable → first address = `base_addr`.
- `freq_sel` changed 3→0 mid-count → next tick occurs 1000 cycles after the change.
- `reset_n`=0 for 1 cycle mid-REQ → next cycle `avm_read`=0, `sample_out`=0, state IDLE.
